// File: rtl/sc_fetch_pkg.sv
// sc_fetch_pkg
//   Shared definitions for the instruction fetch sequencer: default bus width,
//   default PC increment and the fetch FSM state encoding.
package sc_fetch_pkg;

    localparam int DEF_DATAWIDTH = 32;
    localparam int DEF_PC_STEP   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

endpackage : sc_fetch_pkg

// File: rtl/sc_fetch_slot.sv
// sc_fetch_slot
//   One-entry valid/ready holding register for a fetched instruction and its PC.
//   Ports:
//     clk_i, rst_n_i       clock / asynchronous active-low reset
//     load_i               capture load_data_i / load_pc_i, set valid
//     load_data_i          instruction word to capture
//     load_pc_i            PC of that instruction
//     clear_i              drop the entry (wins over load and consume)
//     consume_i            downstream accepted the entry
//     valid_o, data_o, pc_o  slot contents
module sc_fetch_slot #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic [W-1:0] load_pc_i,
    input  logic         clear_i,
    input  logic         consume_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [W-1:0] pc_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic [W-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            // A refill on the consume edge keeps valid high with the new word.
            valid_d = 1'b1;
            data_d  = load_data_i;
            pc_d    = load_pc_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule : sc_fetch_slot

// File: rtl/sc_fetch_unit.sv
// sc_fetch_unit
//   Instruction fetch sequencer. Samples the PC register, issues one req/ack
//   memory read at a time, parks the returned word in a 1-entry slot for decode
//   and writes the PC register (PC+STEP after a fetch, target on redirect).
//   Ports:
//     SC_FETCH_CLOCK_50 / SC_FETCH_RESET_InLow    clock, async active-low reset
//     SC_FETCH_pc_InBUS                           current PC register value
//     SC_FETCH_pcLoad_OutLow / pcNext_OutBUS      PC register write (1-cycle low pulse)
//     SC_FETCH_memReq_Out / memAddr_OutBUS        memory read request / address
//     SC_FETCH_memAck_In / memData_InBUS          memory ack / returned word
//     SC_FETCH_redirect_In / redirectPC_InBUS     taken branch from execute
//     SC_FETCH_stall_In                           blocks new requests only
//     SC_FETCH_instrValid_Out / instr / instrPC   slot towards decode
//     SC_FETCH_decodeReady_In                     decode accepts the slot
//
//   state | meaning
//   IDLE  | no request outstanding, waiting for slot space and no stall
//   REQ   | memReq high, waiting for ack; ack data goes to the slot
//   FLUSH | redirected while waiting; ack data is discarded
module sc_fetch_unit
    import sc_fetch_pkg::*;
#(
    parameter int FETCH_DATAWIDTH = DEF_DATAWIDTH,
    parameter int FETCH_PC_STEP   = DEF_PC_STEP
) (
    input  logic                       SC_FETCH_CLOCK_50,
    input  logic                       SC_FETCH_RESET_InLow,
    input  logic [FETCH_DATAWIDTH-1:0] SC_FETCH_pc_InBUS,
    output logic                       SC_FETCH_pcLoad_OutLow,
    output logic [FETCH_DATAWIDTH-1:0] SC_FETCH_pcNext_OutBUS,
    output logic                       SC_FETCH_memReq_Out,
    output logic [FETCH_DATAWIDTH-1:0] SC_FETCH_memAddr_OutBUS,
    input  logic                       SC_FETCH_memAck_In,
    input  logic [FETCH_DATAWIDTH-1:0] SC_FETCH_memData_InBUS,
    input  logic                       SC_FETCH_redirect_In,
    input  logic [FETCH_DATAWIDTH-1:0] SC_FETCH_redirectPC_InBUS,
    input  logic                       SC_FETCH_stall_In,
    output logic                       SC_FETCH_instrValid_Out,
    output logic [FETCH_DATAWIDTH-1:0] SC_FETCH_instr_OutBUS,
    output logic [FETCH_DATAWIDTH-1:0] SC_FETCH_instrPC_OutBUS,
    input  logic                       SC_FETCH_decodeReady_In
);

    localparam int W = FETCH_DATAWIDTH;

    fetch_state_e state_q, state_d;
    logic         mem_req_q, mem_req_d;
    logic [W-1:0] mem_addr_q, mem_addr_d;
    logic         pc_load_n_q, pc_load_n_d;
    logic [W-1:0] pc_next_q, pc_next_d;

    logic         slot_load;
    logic         slot_clear;
    logic         slot_consume;
    logic         slot_valid;
    logic [W-1:0] slot_data;
    logic [W-1:0] slot_pc;

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        pc_load_n_d  = 1'b1;
        pc_next_d    = pc_next_q;
        slot_load    = 1'b0;
        slot_clear   = 1'b0;
        slot_consume = slot_valid & SC_FETCH_decodeReady_In;

        // Redirect overrides everything: reload PC and kill the slot, even if
        // decode is taking it this very cycle.
        if (SC_FETCH_redirect_In) begin
            pc_load_n_d = 1'b0;
            pc_next_d   = SC_FETCH_redirectPC_InBUS;
            slot_clear  = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!SC_FETCH_redirect_In && !SC_FETCH_stall_In &&
                    (!slot_valid || slot_consume)) begin
                    state_d    = ST_REQ;
                    mem_req_d  = 1'b1;
                    // memAddr doubles as the PC recorded with the returned word.
                    mem_addr_d = SC_FETCH_pc_InBUS;
                end
            end
            ST_REQ: begin
                if (SC_FETCH_memAck_In) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    if (!SC_FETCH_redirect_In) begin
                        slot_load   = 1'b1;
                        pc_load_n_d = 1'b0;
                        pc_next_d   = mem_addr_q + W'(FETCH_PC_STEP);
                    end
                end else if (SC_FETCH_redirect_In) begin
                    // The read cannot be cancelled; keep memReq up and drain it.
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (SC_FETCH_memAck_In) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge SC_FETCH_CLOCK_50 or negedge SC_FETCH_RESET_InLow) begin
        if (!SC_FETCH_RESET_InLow) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            pc_load_n_q <= 1'b1;
            pc_next_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            pc_load_n_q <= pc_load_n_d;
            pc_next_q   <= pc_next_d;
        end
    end

    sc_fetch_slot #(
        .W (W)
    ) u_slot (
        .clk_i       (SC_FETCH_CLOCK_50),
        .rst_n_i     (SC_FETCH_RESET_InLow),
        .load_i      (slot_load),
        .load_data_i (SC_FETCH_memData_InBUS),
        .load_pc_i   (mem_addr_q),
        .clear_i     (slot_clear),
        .consume_i   (slot_consume),
        .valid_o     (slot_valid),
        .data_o      (slot_data),
        .pc_o        (slot_pc)
    );

    assign SC_FETCH_pcLoad_OutLow  = pc_load_n_q;
    assign SC_FETCH_pcNext_OutBUS  = pc_next_q;
    assign SC_FETCH_memReq_Out     = mem_req_q;
    assign SC_FETCH_memAddr_OutBUS = mem_addr_q;
    assign SC_FETCH_instrValid_Out = slot_valid;
    assign SC_FETCH_instr_OutBUS   = slot_data;
    assign SC_FETCH_instrPC_OutBUS = slot_pc;

endmodule : sc_fetch_unit

// File: tb/tb_sc_fetch_unit.sv
// tb_sc_fetch_unit
//   Directed bench for sc_fetch_unit with a behavioural PC register that loads
//   on the falling clock edge while pcLoad is low.
module tb_sc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_reg;
    logic [31:0] pc_preset;
    logic        pc_load_n;
    logic [31:0] pc_next;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        decode_ready;

    int checks   = 0;
    int failures = 0;

    sc_fetch_unit dut (
        .SC_FETCH_CLOCK_50         (clk),
        .SC_FETCH_RESET_InLow      (rst_n),
        .SC_FETCH_pc_InBUS         (pc_reg),
        .SC_FETCH_pcLoad_OutLow    (pc_load_n),
        .SC_FETCH_pcNext_OutBUS    (pc_next),
        .SC_FETCH_memReq_Out       (mem_req),
        .SC_FETCH_memAddr_OutBUS   (mem_addr),
        .SC_FETCH_memAck_In        (mem_ack),
        .SC_FETCH_memData_InBUS    (mem_data),
        .SC_FETCH_redirect_In      (redirect),
        .SC_FETCH_redirectPC_InBUS (redirect_pc),
        .SC_FETCH_stall_In         (stall),
        .SC_FETCH_instrValid_Out   (instr_valid),
        .SC_FETCH_instr_OutBUS     (instr),
        .SC_FETCH_instrPC_OutBUS   (instr_pc),
        .SC_FETCH_decodeReady_In   (decode_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register: preset on reset, loads on the falling edge.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) pc_reg <= pc_preset;
        else if (!pc_load_n) pc_reg <= pc_next;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, mem_req}, 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},    {31'd0, mem_req},     32'd0);
        chk({tag, "_addr"},   mem_addr,             32'd0);
        chk({tag, "_pcld"},   {31'd0, pc_load_n},   32'd1);
        chk({tag, "_pcnext"}, pc_next,              32'd0);
        chk({tag, "_valid"},  {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"},  instr,                32'd0);
        chk({tag, "_ipc"},    instr_pc,             32'd0);
    endtask

    initial begin
        rst_n        = 1'b1;
        pc_preset    = 32'h0000_0800;
        mem_ack      = 1'b0;
        mem_data     = 32'd0;
        redirect     = 1'b0;
        redirect_pc  = 32'd0;
        stall        = 1'b0;
        decode_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_reset("rst");
        tick();
        tick();
        rst_n = 1'b1;

        // 1: zero-wait fetches from 0x800
        wait_req("t1_req");
        chk("t1_addr", mem_addr, 32'h0000_0800);
        mem_ack = 1'b1; mem_data = 32'hA000_0001;
        tick();
        mem_ack = 1'b0;
        chk("t1_valid",  {31'd0, instr_valid}, 32'd1);
        chk("t1_instr",  instr,                32'hA000_0001);
        chk("t1_ipc",    instr_pc,             32'h0000_0800);
        chk("t1_pcld",   {31'd0, pc_load_n},   32'd0);
        chk("t1_pcnext", pc_next,              32'h0000_0804);
        chk("t1_req_lo", {31'd0, mem_req},     32'd0);
        tick();
        chk("t1_pcld_hi", {31'd0, pc_load_n},   32'd1);
        chk("t1_req2",    {31'd0, mem_req},     32'd1);
        chk("t1_addr2",   mem_addr,             32'h0000_0804);
        chk("t1_consumed",{31'd0, instr_valid}, 32'd0);
        mem_ack = 1'b1; mem_data = 32'hA000_0002;
        tick();
        mem_ack = 1'b0;
        chk("t1_ipc2",    instr_pc, 32'h0000_0804);
        chk("t1_pcnext2", pc_next,  32'h0000_0808);

        // 2: ack delayed 5 cycles
        tick();
        chk("t2_req",  {31'd0, mem_req}, 32'd1);
        chk("t2_addr", mem_addr,         32'h0000_0808);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_req_hold",  {31'd0, mem_req},   32'd1);
            chk("t2_addr_hold", mem_addr,           32'h0000_0808);
            chk("t2_no_pcld",   {31'd0, pc_load_n}, 32'd1);
        end
        mem_ack = 1'b1; mem_data = 32'hB000_0003;
        tick();
        mem_ack = 1'b0;
        chk("t2_pcld",   {31'd0, pc_load_n}, 32'd0);
        chk("t2_pcnext", pc_next,            32'h0000_080C);
        chk("t2_instr",  instr,              32'hB000_0003);
        tick();
        chk("t2_pcld_once", {31'd0, pc_load_n}, 32'd1);
        chk("t2_next_addr", mem_addr,           32'h0000_080C);

        // 3: redirect during REQ before ack -> FLUSH
        redirect = 1'b1; redirect_pc = 32'h0000_1000;
        tick();
        redirect = 1'b0;
        chk("t3_req_held", {31'd0, mem_req},   32'd1);
        chk("t3_pcld",     {31'd0, pc_load_n}, 32'd0);
        chk("t3_pcnext",   pc_next,            32'h0000_1000);
        tick();
        chk("t3_flush_req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        chk("t3_drop_valid", {31'd0, instr_valid}, 32'd0);
        chk("t3_req_lo",     {31'd0, mem_req},     32'd0);
        tick();
        chk("t3_req2",  {31'd0, mem_req}, 32'd1);
        chk("t3_addr2", mem_addr,         32'h0000_1000);

        // 4a: redirect in the ack cycle
        redirect = 1'b1; redirect_pc = 32'h0000_2000;
        mem_ack = 1'b1; mem_data = 32'h0BAD_0BAD;
        tick();
        redirect = 1'b0; mem_ack = 1'b0;
        chk("t4_drop_valid", {31'd0, instr_valid}, 32'd0);
        chk("t4_pcld",       {31'd0, pc_load_n},   32'd0);
        chk("t4_pcnext",     pc_next,              32'h0000_2000);
        tick();
        chk("t4_addr2", mem_addr, 32'h0000_2000);
        // 4b: redirect while slot valid and decode ready
        mem_ack = 1'b1; mem_data = 32'hC000_0004;
        tick();
        mem_ack = 1'b0;
        chk("t4_valid", {31'd0, instr_valid}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_3000;
        tick();
        redirect = 1'b0;
        chk("t4_cleared", {31'd0, instr_valid}, 32'd0);
        chk("t4_pcnext2", pc_next,              32'h0000_3000);
        tick();
        chk("t4_addr3", mem_addr, 32'h0000_3000);

        // 5: decode not ready for 10 cycles
        decode_ready = 1'b0;
        mem_ack = 1'b1; mem_data = 32'hE000_0005;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_no_req", {31'd0, mem_req},     32'd0);
            chk("t5_valid",  {31'd0, instr_valid}, 32'd1);
            chk("t5_instr",  instr,                32'hE000_0005);
            chk("t5_ipc",    instr_pc,             32'h0000_3000);
        end
        decode_ready = 1'b1;
        tick();
        chk("t5_taken", {31'd0, instr_valid}, 32'd0);
        chk("t5_req",   {31'd0, mem_req},     32'd1);
        chk("t5_addr",  mem_addr,             32'h0000_3004);
        mem_ack = 1'b1; mem_data = 32'h0000_000F;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("t6_midreq", {31'd0, mem_req}, 32'd1);

        // 6: async reset mid-REQ, then wrap of PC arithmetic
        #2;
        pc_preset = 32'hFFFF_FFFC;
        rst_n = 1'b0;
        #1;
        chk_reset("t6_arst");
        tick();
        tick();
        rst_n = 1'b1;
        wait_req("t6_req");
        chk("t6_addr", mem_addr, 32'hFFFF_FFFC);
        mem_ack = 1'b1; mem_data = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        chk("t6_pcnext_wrap", pc_next,  32'h0000_0000);
        chk("t6_ipc",         instr_pc, 32'hFFFF_FFFC);
        tick();
        chk("t6_addr_wrap", mem_addr, 32'h0000_0000);

        // stall blocks new requests but not the slot handoff
        mem_ack = 1'b1; mem_data = 32'h5555_AAAA;
        tick();
        mem_ack = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_req", {31'd0, mem_req},     32'd0);
            chk("stall_handoff",{31'd0, instr_valid}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("stall_release_req", {31'd0, mem_req}, 32'd1);
        chk("stall_release_addr", mem_addr,        32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sc_fetch_unit
